// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory access controller:
// phase encodings, the halt command address and default bus widths.
package imem_pkg;

  localparam int DEF_AW = 10;
  localparam int DEF_DW = 32;

  // The wait counter only needs to reach MAX_WAIT, which is at most 15.
  localparam int WAIT_W = 4;

  localparam logic [DEF_AW-1:0] HALT_ADDR = '1;

  typedef enum logic [1:0] {
    PH_BOOT = 2'b00,
    PH_RUN  = 2'b01,
    PH_HALT = 2'b10
  } phase_t;

  // BOOT and HALT both hand the whole port to the loader.
  function automatic logic loader_owns_port(input phase_t ph);
    return (ph != PH_RUN);
  endfunction

endpackage

// File: rtl/imem_wait_counter.sv
// Saturating starvation counter for the loader: counts refused cycles and
// flags when the loader must be forced through.
module imem_wait_counter
  import imem_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic inc,
  output logic sat
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;

  // Clear has priority so a write accepted on the forced slot restarts the count.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wait_cnt <= '0;
    end else if (clr) begin
      wait_cnt <= '0;
    end else if (inc && (wait_cnt != MAX_CNT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign sat = (wait_cnt == MAX_CNT);

endmodule

// File: rtl/imem_access_ctrl.sv
// Shares the single-port instruction memory between the read-only fetch unit
// and the write-only program loader, with BOOT / RUN / HALT phases.
module imem_access_ctrl
  import imem_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int DEPTH    = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          boot_done,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_valid,
  output logic [DW-1:0] fetch_data,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  input  logic [DW-1:0] mem_q,
  output logic [1:0]    phase,
  output logic          addr_err,
  output logic [AW:0]   load_count
);

  localparam logic [AW:0]   DEPTH_LIM = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] HALT_A    = {AW{1'b1}};

  phase_t phase_q;

  logic wait_sat;
  logic fetch_win;
  logic ld_accept;
  logic halt_cmd;
  logic ld_in_range;
  logic fetch_in_range;
  logic ld_write;

  assign ld_in_range    = ({1'b0, ld_addr} < DEPTH_LIM);
  assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_LIM);

  // Fetch has priority in RUN until the loader has been refused MAX_WAIT times.
  assign fetch_win = (phase_q == PH_RUN) && fetch_req && !wait_sat;
  assign fetch_gnt = fetch_win;
  assign ld_ready  = !fetch_win;
  assign ld_accept = ld_valid && ld_ready;

  // The halt command is consumed like a write but never reaches the memory.
  assign halt_cmd = (phase_q == PH_RUN) && ld_accept && (ld_addr == HALT_A);
  assign ld_write = ld_accept && ld_in_range && !halt_cmd;

  imem_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_counter (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (!ld_valid || ld_accept),
    .inc   (ld_valid && !ld_ready),
    .sat   (wait_sat)
  );

  // Write enable is gated by RESET so nothing is written while reset is held.
  always_comb begin
    mem_addr = fetch_addr;
    mem_data = ld_data;
    mem_we   = 1'b0;
    if (loader_owns_port(phase_q) || ld_accept) begin
      mem_addr = ld_addr;
    end
    if (ld_write && !RESET) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      phase_q <= PH_BOOT;
    end else begin
      case (phase_q)
        PH_BOOT: if (boot_done) phase_q <= PH_RUN;
        PH_RUN:  if (halt_cmd)  phase_q <= PH_HALT;
        PH_HALT: if (boot_done) phase_q <= PH_RUN;
        default: phase_q <= PH_BOOT;
      endcase
    end
  end

  assign phase = phase_q;

  // Read data is captured one cycle after the grant; out-of-range reads give 0.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
    end else begin
      fetch_valid <= fetch_win;
      if (fetch_win) begin
        fetch_data <= fetch_in_range ? mem_q : '0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr_err   <= 1'b0;
      load_count <= '0;
    end else begin
      if ((fetch_win && !fetch_in_range) ||
          (ld_accept && !ld_in_range && !halt_cmd)) begin
        addr_err <= 1'b1;
      end
      if (ld_write && (load_count != '1)) begin
        load_count <= load_count + 1'b1;
      end
    end
  end

endmodule
